fme_clip_arbiter: RTL and testbench
===================================

# fme_clip_arbiter

Round-robin arbiter that shares one registered clip stage (10-bit signed in, 8-bit unsigned saturated out) among several FME interpolation filters: half-pel horizontal, vertical and diagonal. Grants are given in bursts of up to BURST beats so a filter row stays contiguous. Each issued sample is tagged with its requester ID and tracked through the clip pipeline. Each result returns on a per-requester valid strobe. The block sits between the filter bank and the shared clip unit in the FMEv2.5 datapath.

## Interface
- DATAWIDTH, 8: clip output width; clip input is DATAWIDTH+2 bits signed.
- NUM_REQ, 3: number of requesters, range 2..8.
- BURST, 4: maximum consecutive beats per grant, range 1..16.
- LATENCY, 1: clip pipeline depth in enabled cycles, range 1..4.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held with data until granted.
- req_data  in  NUM_REQ*(DATAWIDTH+2)  packed signed samples; requester i occupies bits [i*(DATAWIDTH+2) +: DATAWIDTH+2].
- gnt  out  NUM_REQ  one-hot grant (combinational); a beat transfers when req[i] & gnt[i].
- clip_enable  out  1  enable to the clip stage.
- clip_in  out  DATAWIDTH+2  sample to the clip stage.
- clip_out  in  DATAWIDTH  clip stage result.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle strobe marking the owner of rsp_data.
- rsp_data  out  DATAWIDTH  result, equal to clip_out.

## Operation
- The FSM has two states. IDLE means no owner. BURST means an owner is registered and beat_cnt counts its beats.
- IDLE: grant goes to the first requester with req high, scanning from ptr upward with wrap-around. If one is found, the beat issues this cycle and the FSM goes to BURST with owner = i and beat_cnt = 1.
- BURST while req[owner] is high and beat_cnt < BURST: gnt[owner] is high, a beat issues and beat_cnt increments.
- BURST when req[owner] drops or beat_cnt == BURST: no grant goes to the owner. ptr becomes (owner+1) mod NUM_REQ. In the same cycle, IDLE arbitration runs from the new ptr, so there is no bubble when another requester is waiting.
- A requester that finishes a burst and still holds req competes again from the new ptr. It cannot take two bursts back to back if any other requester is waiting.
- Issue: clip_in is the mux of req_data[owner]. clip_in is 0 when no beat issues.
- Tag pipeline: LATENCY stages of {valid, id}. A new tag enters at an issue. The pipeline shifts only when clip_enable is high.
- clip_enable = issue OR any tag valid. The clip stage and the tags advance in lockstep, so bubbles are preserved.
- rsp_valid[id] is high when the last tag stage is valid and clip_enable was high in the previous cycle; it is 0 otherwise.
- Saturation is done by the clip unit, not by this block: a negative input gives 0, and an input above 255 gives 255.

## Timing
- Reset, asynchronous: state = IDLE, ptr = 0, beat_cnt = 0, all tags invalid. While reset_n is low, gnt, clip_enable and rsp_valid are all 0 and clip_in = 0.
- Reset mid-burst or with samples in flight: in-flight results are discarded. No rsp_valid pulse occurs for them after reset releases.
- Issue-to-response latency is LATENCY cycles under continuous issue. Idle cycles after an issue still count, because clip_enable stays high while any tag is valid.
- Peak throughput is one beat per cycle across all requesters.
- If req drops in the same cycle the burst limit is reached, the block behaves as at the limit: ptr advances once.
- If all req bits drop, the FSM returns to IDLE and ptr advances past the last owner.

## Structure
- Shared package fme_pkg: requester ID width function clog2(NUM_REQ), burst counter width, FSM state enum {IDLE, BURST}, and named requester indices REQ_H = 0, REQ_V = 1, REQ_D = 2.
- One natural sub-module: fme_rr_pick. It is a combinational round-robin priority pick from ptr with wrap, producing a one-hot grant and an index.
- The tag pipeline and the FSM stay in the top module.

## Test plan
- Single requester: req[0] held for 6 beats with data 100, -5, 300, 255, 256, 0. Required response: bursts of 4 then 2 with one bubble at the burst edge (same requester re-wins). rsp_valid[0] pulses 1 cycle after each issue with 100, 0, 255, 255, 255, 0.
- All three req high continuously, BURST = 4: grant order is 0×4, 1×4, 2×4, 0×4. No idle cycle between owners. Each rsp_valid strobe matches the issuing ID.
- Early release: req[1] drops after 2 beats while req[2] is waiting. gnt[2] rises in the same cycle req[1] is low, and ptr = 2.
- Wrap: ptr = 2 with only req[0] high. Required response: gnt[0] is granted immediately.
- LATENCY = 3 with a single issue followed by idle: clip_enable stays high for 3 cycles. rsp_valid arrives exactly 3 cycles after issue, then clip_enable = 0.
- reset_n pulsed low with 2 beats in flight: outputs are 0 immediately. After release, no stale rsp_valid appears and the first grant goes to the lowest requesting ID from ptr = 0.

Source files
------------

// File: rtl/fme_pkg.sv
// fme_pkg: shared types, widths and requester names for the FME clip arbiter
package fme_pkg;
  localparam int REQ_H = 0;
  localparam int REQ_V = 1;
  localparam int REQ_D = 2;
  typedef enum logic {ST_IDLE, ST_BURST} state_t;
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int cnt_width(input int b);
    return $clog2(b + 1);
  endfunction
endpackage

// File: rtl/fme_rr_pick.sv
// fme_rr_pick: round-robin pick of the first request at or above ptr, with wrap
module fme_rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         found
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;
  // rotate so bit 0 is ptr, take the lowest set bit, map back to an index
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? W'(k) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    found = |req;
    gnt = found ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/fme_clip_arbiter.sv
// fme_clip_arbiter: burst round-robin sharing of one clip stage with tagged responses
module fme_clip_arbiter
  import fme_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NUM_REQ   = 3,
  parameter int BURST     = 4,
  parameter int LATENCY   = 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*(DATAWIDTH+2)-1:0]  req_data,
  output logic [NUM_REQ-1:0]                gnt,
  output logic                              clip_enable,
  output logic [DATAWIDTH+1:0]              clip_in,
  input  logic [DATAWIDTH-1:0]              clip_out,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATAWIDTH-1:0]              rsp_data
);
  localparam int IW = id_width(NUM_REQ);
  localparam int CW = cnt_width(BURST);
  localparam int XW = DATAWIDTH + 2;
  state_t              state, state_nx;
  logic [IW-1:0]       ptr, ptr_nx, owner, owner_nx, arb_ptr, pick_idx, issue_id;
  logic [CW-1:0]       beat_cnt, cnt_nx;
  logic [NUM_REQ-1:0]  arb_req, pick_gnt;
  logic                pick_found, cont, issue, en_q;
  logic [LATENCY-1:0]  tag_v;
  logic [IW-1:0]       tag_id [LATENCY];
  logic [XW-1:0]       data [NUM_REQ];
  // unpack per-requester samples
  always_comb for (int i = 0; i < NUM_REQ; i++) data[i] = req_data[i*XW +: XW];
  // an owner that just finished is excluded so others get the next burst
  assign cont    = reset_n && state == ST_BURST && req[owner] && beat_cnt < CW'(BURST);
  assign arb_ptr = (state == ST_BURST) ? ((owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1) : ptr;
  assign arb_req = reset_n ? ((state == ST_BURST) ? req & ~(NUM_REQ'(1) << owner) : req) : '0;
  fme_rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .req   (arb_req),
    .ptr   (arb_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );
  // grant, issue mux and next-state decisions
  always_comb begin
    issue       = cont | pick_found;
    issue_id    = cont ? owner : pick_idx;
    gnt         = cont ? NUM_REQ'(1) << owner : pick_gnt;
    clip_in     = issue ? data[issue_id] : '0;
    clip_enable = issue | (|tag_v);
    state_nx    = issue ? ST_BURST : ST_IDLE;
    owner_nx    = issue ? issue_id : owner;
    cnt_nx      = cont ? beat_cnt + 1'b1 : (pick_found ? CW'(1) : '0);
    ptr_nx      = cont ? ptr : arb_ptr;
    rsp_valid   = (tag_v[LATENCY-1] && en_q) ? NUM_REQ'(1) << tag_id[LATENCY-1] : '0;
    rsp_data    = clip_out;
  end
  // arbitration state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner    <= owner_nx;
      beat_cnt <= cnt_nx;
    end
  end
  // tag valids move in lockstep with the clip stage; reset discards in-flight work
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= clip_enable;
      if (clip_enable) tag_v <= LATENCY'({tag_v, issue});
    end
  end
  // tag ids only matter where the matching valid is set
  always_ff @(posedge clock) begin
    if (clip_enable) begin
      tag_id[0] <= issue_id;
      for (int i = 1; i < LATENCY; i++) tag_id[i] <= tag_id[i-1];
    end
  end
endmodule

// File: tb/tb_fme_clip_arbiter.sv
// tb_fme_clip_arbiter: directed and random checks against a behavioural arbiter model
module tb_fme_clip_arbiter;
  localparam int N = 3;
  localparam int B = 4;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  req, gnt, rsp_valid;
  logic [9:0]  dat [N];
  logic [29:0] req_data;
  logic        clip_enable;
  logic [9:0]  clip_in;
  logic [7:0]  clip_out, rsp_data, clip_q;
  logic [2:0]  req3, gnt3, rsp_valid3;
  logic [9:0]  d3, clip_in3;
  logic        clip_enable3;
  logic [7:0]  clip_out3, rsp_data3;
  logic [7:0]  p3 [3];
  int pass = 0, total = 0;
  int m_ptr, m_own, m_cnt, p_id, last_g;
  bit m_inb, p_iss;
  logic [9:0] p_dat;

  always #5 clock = ~clock;
  assign req_data = {dat[2], dat[1], dat[0]};

  fme_clip_arbiter dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data), .gnt(gnt),
    .clip_enable(clip_enable), .clip_in(clip_in), .clip_out(clip_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );
  fme_clip_arbiter #(.LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .req(req3), .req_data({10'd0, d3, d3}), .gnt(gnt3),
    .clip_enable(clip_enable3), .clip_in(clip_in3), .clip_out(clip_out3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3)
  );

  function automatic logic [7:0] sat(input logic [9:0] x);
    return ($signed(x) < 0) ? 8'd0 : (($signed(x) > 255) ? 8'd255 : x[7:0]);
  endfunction

  // clip units: saturate, advancing only when enabled
  always @(posedge clock) if (clip_enable) clip_q <= sat(clip_in);
  assign clip_out = clip_q;
  always @(posedge clock) if (clip_enable3) begin
    p3[0] <= sat(clip_in3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign clip_out3 = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_init();
    m_ptr = 0; m_own = 0; m_cnt = 0; m_inb = 0; p_iss = 0; last_g = -1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; req3 = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_init();
  endtask

  // one cycle against the model; inputs are already driven
  task automatic cyc();
    int g, p, j;
    bit cont;
    logic [9:0] d;
    g = -1;
    cont = m_inb && req[m_own] && m_cnt < B;
    if (cont) g = m_own;
    else begin
      p = m_inb ? (m_own + 1) % N : m_ptr;
      for (int k = 0; k < N; k++) begin
        j = (p + k) % N;
        if (g < 0 && req[j] && !(m_inb && j == m_own)) g = j;
      end
    end
    d = (g >= 0) ? dat[g] : 10'd0;
    @(negedge clock);
    chk("gnt", 32'(gnt), (g >= 0) ? 32'(1 << g) : 32'd0);
    chk("clip_in", 32'(clip_in), 32'(d));
    chk("clip_enable", 32'(clip_enable), 32'((g >= 0) || p_iss));
    chk("rsp_valid", 32'(rsp_valid), p_iss ? 32'(1 << p_id) : 32'd0);
    if (p_iss) chk("rsp_data", 32'(rsp_data), 32'(sat(p_dat)));
    @(posedge clock);
    if (cont) m_cnt++;
    else begin
      if (m_inb) m_ptr = (m_own + 1) % N;
      if (g >= 0) begin m_inb = 1; m_own = g; m_cnt = 1; end
      else m_inb = 0;
    end
    p_iss = (g >= 0); p_id = g; p_dat = d; last_g = g;
    #1;
  endtask

  initial begin
    logic [9:0] vals [6];
    int ord [16];
    int idx, n;
    vals[0] = 10'd100; vals[1] = -10'sd5; vals[2] = 10'd300;
    vals[3] = 10'd255; vals[4] = 10'd256; vals[5] = 10'd0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    d3 = '0;
    do_reset();
    // reset state
    @(negedge clock);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_enable", 32'(clip_enable), 0);
    chk("reset_rsp", 32'(rsp_valid), 0);
    @(posedge clock); #1;
    // single requester: 4-beat burst, bubble, 2 beats
    idx = 0; n = 0; req = 3'b001; dat[0] = vals[0];
    while (idx < 6 && n < 20) begin
      cyc(); n++;
      if (last_g == 0) idx++;
      if (idx < 6) dat[0] = vals[idx];
    end
    chk("single_cycles", 32'(n), 7);
    req = '0; cyc(); cyc();
    // all three requesting continuously
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < N; r++) dat[r] = 10'($urandom);
      cyc(); ord[i] = last_g;
    end
    for (int i = 0; i < 16; i++) chk("order", 32'(ord[i]), (i < 4 || i >= 12) ? 0 : (i < 8 ? 1 : 2));
    req = '0; cyc();
    // early release hands over with no bubble
    do_reset();
    req = 3'b110; cyc(); cyc();
    req = 3'b100; cyc();
    chk("early_release", 32'(last_g), 2);
    req = '0; cyc();
    // wrap from ptr 2 to requester 0
    do_reset();
    req = 3'b010; cyc(); cyc();
    req = 3'b000; cyc();
    req = 3'b001; cyc();
    chk("wrap", 32'(last_g), 0);
    req = '0; cyc();
    // reset with a beat in flight
    do_reset();
    req = 3'b111; cyc(); cyc();
    reset_n = 1'b0; #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_enable", 32'(clip_enable), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_clip_in", 32'(clip_in), 0);
    @(posedge clock); #1 reset_n = 1'b1;
    model_init();
    req = 3'b110; cyc();
    chk("post_rst_first", 32'(last_g), 1);
    cyc();
    // LATENCY 3: single issue then idle
    do_reset();
    req3 = 3'b001; d3 = 10'd50;
    @(negedge clock);
    chk("l3_gnt", 32'(gnt3), 1);
    chk("l3_issue_en", 32'(clip_enable3), 1);
    chk("l3_clip_in", 32'(clip_in3), 50);
    @(posedge clock); #1 req3 = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk("l3_en", 32'(clip_enable3), 1);
      chk("l3_rsp", 32'(rsp_valid3), (k == 3) ? 1 : 0);
      if (k == 3) chk("l3_data", 32'(rsp_data3), 50);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("l3_en_off", 32'(clip_enable3), 0);
    chk("l3_rsp_off", 32'(rsp_valid3), 0);
    // LATENCY 3: reset with two beats in flight
    @(posedge clock); #1 req3 = 3'b011; d3 = 10'd7;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b0; #1;
    chk("l3_rst_gnt", 32'(gnt3), 0);
    chk("l3_rst_en", 32'(clip_enable3), 0);
    chk("l3_rst_rsp", 32'(rsp_valid3), 0);
    @(posedge clock); #1 reset_n = 1'b1; req3 = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("l3_stale", 32'(rsp_valid3), 0);
    end
    // random traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req = 3'($urandom_range(0, 7));
      for (int r = 0; r < N; r++) dat[r] = 10'($urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
